// File: rtl/pm_emulator.sv
// Pixel-matrix column emulator: 32 columns of 16-bit shift, count and config registers.
// Optional per-column hit counters are built only when PM_EMULATOR_COUNTER_EN is defined.
module pm_emulator (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clkSh,
    input  logic              shA,
    input  logic              shB,
    input  logic              gate,
    input  logic              strobe,
    input  logic              write_cfg,
    input  logic [31:0]       pm_din,
    output logic [31:0]       pm_dout,
    output logic [31:0][15:0] cfg_out
);

    localparam int NCOL = 32;

    logic        clksh_prev;
    logic        shb_prev;
    logic        strobe_prev;
    logic        write_cfg_prev;
    logic        armed;

    logic        clksh_rise;
    logic        shb_rise;
    logic        strobe_rise;
    logic        write_cfg_rise;
    logic        do_shift;
    logic        do_load;

    logic [15:0] sr  [NCOL];
    logic [15:0] cfg [NCOL];

    // armed stays low for the first cycle after reset so that inputs already
    // high at release are absorbed into the prev copies instead of firing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clksh_prev     <= 1'b0;
            shb_prev       <= 1'b0;
            strobe_prev    <= 1'b0;
            write_cfg_prev <= 1'b0;
            armed          <= 1'b0;
        end else begin
            clksh_prev     <= clkSh;
            shb_prev       <= shB;
            strobe_prev    <= strobe;
            write_cfg_prev <= write_cfg;
            armed          <= 1'b1;
        end
    end

    assign clksh_rise     = armed & clkSh     & ~clksh_prev;
    assign shb_rise       = armed & shB       & ~shb_prev;
    assign strobe_rise    = armed & strobe    & ~strobe_prev;
    assign write_cfg_rise = armed & write_cfg & ~write_cfg_prev;

    // shA selects exactly one of shift or load, so they can never collide.
    assign do_shift = clksh_rise & shA;
    assign do_load  = shb_rise & ~shA;

`ifdef PM_EMULATOR_COUNTER_EN
    logic        do_count;
    logic [15:0] cnt [NCOL];

    assign do_count = strobe_rise & gate;

    // A hit coinciding with a load lands in the freshly cleared counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCOL; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCOL; c++) begin
                if (do_load) begin
                    cnt[c] <= do_count ? 16'd1 : 16'd0;
                end else if (do_count && (cnt[c] != 16'hFFFF)) begin
                    cnt[c] <= cnt[c] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCOL; c++) begin
                sr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCOL; c++) begin
                if (do_shift) begin
                    sr[c] <= {sr[c][14:0], pm_din[c]};
                end else if (do_load) begin
                    sr[c] <= cnt[c];
                end
            end
        end
    end
`else
    logic unused_count_inputs;

    assign unused_count_inputs = &{1'b0, gate, strobe_rise};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCOL; c++) begin
                sr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCOL; c++) begin
                if (do_shift) begin
                    sr[c] <= {sr[c][14:0], pm_din[c]};
                end else if (do_load) begin
                    sr[c] <= '0;
                end
            end
        end
    end
`endif

    // cfg samples sr before any same-cycle shift or load takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCOL; c++) begin
                cfg[c] <= '0;
            end
        end else if (write_cfg_rise) begin
            for (int c = 0; c < NCOL; c++) begin
                cfg[c] <= sr[c];
            end
        end
    end

    always_comb begin
        pm_dout = '0;
        cfg_out = '0;
        for (int c = 0; c < NCOL; c++) begin
            pm_dout[c] = sr[c][15];
            cfg_out[c] = cfg[c];
        end
    end

endmodule

// File: tb/tb_pm_emulator.sv
// Directed bench for pm_emulator: vector table for shift/config plus hand-written corner sequences.
module tb_pm_emulator;

    logic              clk;
    logic              rst_n;
    logic              clkSh;
    logic              shA;
    logic              shB;
    logic              gate;
    logic              strobe;
    logic              write_cfg;
    logic [31:0]       pm_din;
    logic [31:0]       pm_dout;
    logic [31:0][15:0] cfg_out;

    int total = 0;
    int bad   = 0;

    pm_emulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clkSh     (clkSh),
        .shA       (shA),
        .shB       (shB),
        .gate      (gate),
        .strobe    (strobe),
        .write_cfg (write_cfg),
        .pm_din    (pm_din),
        .pm_dout   (pm_dout),
        .cfg_out   (cfg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        int          col;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic clksh_pulse();
        @(negedge clk) clkSh = 1'b1;
        @(negedge clk) clkSh = 1'b0;
    endtask

    task automatic shb_pulse();
        @(negedge clk) shB = 1'b1;
        @(negedge clk) shB = 1'b0;
    endtask

    task automatic cfg_pulse();
        @(negedge clk) write_cfg = 1'b1;
        @(negedge clk) write_cfg = 1'b0;
    endtask

    task automatic strobe_pulse();
        @(negedge clk) strobe = 1'b1;
        @(negedge clk) strobe = 1'b0;
    endtask

    // Shift word MSB-first into col; every other column receives ~word.
    task automatic shift_in(input int col, input logic [15:0] word);
        shA = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            pm_din      = {32{~word[i]}};
            pm_din[col] = word[i];
            clksh_pulse();
        end
        pm_din = '0;
    endtask

    task automatic shift_all(input logic [15:0] word);
        shA = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            pm_din = {32{word[i]}};
            clksh_pulse();
        end
        pm_din = '0;
    endtask

    // Collect 16 bits of col MSB-first while shifting zeros in.
    task automatic read_col(input int col, output logic [15:0] word);
        shA    = 1'b1;
        pm_din = '0;
        for (int i = 15; i >= 0; i--) begin
            word[i] = pm_dout[col];
            clksh_pulse();
        end
    endtask

`ifdef PM_EMULATOR_COUNTER_EN
    task automatic load_and_read(input int col, output logic [15:0] word);
        shA = 1'b0;
        shb_pulse();
        read_col(col, word);
    endtask
`endif

    initial begin
        logic [15:0] w;
        logic [15:0] w2;
        logic [4:0]  pair;

        vecs[0] = '{word: 16'h1234, col: 7,  exp: 16'h1234};
        vecs[1] = '{word: 16'hFFFF, col: 31, exp: 16'hFFFF};
        vecs[2] = '{word: 16'h0001, col: 0,  exp: 16'h0001};
        vecs[3] = '{word: 16'h8000, col: 16, exp: 16'h8000};
        vecs[4] = '{word: 16'h5A5A, col: 3,  exp: 16'h5A5A};

        rst_n = 1'b0; clkSh = 1'b0; shA = 1'b0; shB = 1'b0;
        gate = 1'b0; strobe = 1'b0; write_cfg = 1'b0; pm_din = '0;
        repeat (3) @(negedge clk);
        check("reset_dout", pm_dout, 32'h0);
        check("reset_cfg_any", {31'h0, |cfg_out}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        shift_in(0, 16'hA5C3);
        read_col(0, w);
        check("shift_a5c3", {16'h0, w}, {16'h0, 16'hA5C3});

        for (int k = 0; k < 5; k++) begin
            pair = 5'(vecs[k].col) ^ 5'd1;
            shift_in(vecs[k].col, vecs[k].word);
            cfg_pulse();
            check($sformatf("vec%0d_cfg", k), {16'h0, cfg_out[vecs[k].col]}, {16'h0, vecs[k].exp});
            check($sformatf("vec%0d_cfg_nb", k), {16'h0, cfg_out[pair]}, {16'h0, ~vecs[k].exp});
            read_col(vecs[k].col, w);
            check($sformatf("vec%0d_out", k), {16'h0, w}, {16'h0, vecs[k].exp});
            check($sformatf("vec%0d_cfg_hold", k), {16'h0, cfg_out[vecs[k].col]}, {16'h0, vecs[k].exp});
        end

        shift_all(16'hC3A5);
        shA = 1'b0; pm_din = '1;
        repeat (3) clksh_pulse();
        read_col(5, w);
        check("shift_gated_by_sha", {16'h0, w}, {16'h0, 16'hC3A5});

        shift_all(16'h0F0F);
        shA = 1'b1;
        shb_pulse();
        read_col(9, w);
        check("load_ignored_sha1", {16'h0, w}, {16'h0, 16'h0F0F});

        shift_all(16'h8421);
        @(negedge clk) begin clkSh = 1'b1; write_cfg = 1'b1; end
        @(negedge clk) begin clkSh = 1'b0; write_cfg = 1'b0; end
        check("cfg_pre_shift", {16'h0, cfg_out[2]}, {16'h0, 16'h8421});
        read_col(2, w);
        check("shift_with_cfg", {16'h0, w}, {16'h0, 16'h0842});

`ifdef PM_EMULATOR_COUNTER_EN
        gate = 1'b1;
        repeat (5) strobe_pulse();
        shA = 1'b0;
        shb_pulse();
        shA = 1'b1;
        w = '0; w2 = '0;
        for (int i = 15; i >= 0; i--) begin
            w[i]  = pm_dout[0];
            w2[i] = pm_dout[31];
            clksh_pulse();
        end
        check("count5_col0", {16'h0, w}, {16'h0, 16'h0005});
        check("count5_col31", {16'h0, w2}, {16'h0, 16'h0005});
        load_and_read(12, w);
        check("count_cleared", {16'h0, w}, {16'h0, 16'h0000});

        repeat (3) strobe_pulse();
        shA = 1'b0;
        @(negedge clk) begin strobe = 1'b1; shB = 1'b1; end
        @(negedge clk) begin strobe = 1'b0; shB = 1'b0; end
        read_col(4, w);
        check("coincide_pre", {16'h0, w}, {16'h0, 16'h0003});
        load_and_read(4, w);
        check("coincide_post", {16'h0, w}, {16'h0, 16'h0001});

        gate = 1'b0;
        repeat (2) strobe_pulse();
        load_and_read(6, w);
        check("gate_low", {16'h0, w}, {16'h0, 16'h0000});

        @(negedge clk);
        for (int c = 0; c < 32; c++) dut.cnt[c] = 16'hFFFE;
        gate = 1'b1;
        repeat (3) strobe_pulse();
        gate = 1'b0;
        load_and_read(20, w);
        check("saturate", {16'h0, w}, {16'h0, 16'hFFFF});
`else
        shift_all(16'hBEEF);
        shA = 1'b0;
        gate = 1'b1;
        repeat (2) strobe_pulse();
        gate = 1'b0;
        shb_pulse();
        check("load_clears_dout", pm_dout, 32'h0);
        read_col(4, w);
        check("load_clears_sr", {16'h0, w}, {16'h0, 16'h0000});
`endif

        shift_all(16'hFFFF);
        cfg_pulse();
        check("pre_reset_dout", pm_dout, 32'hFFFF_FFFF);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midreset_dout", pm_dout, 32'h0);
        check("midreset_cfg_any", {31'h0, |cfg_out}, 32'h0);

        shA = 1'b1; clkSh = 1'b1; pm_din = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clkSh = 1'b0; pm_din = '0;
        @(negedge clk);
        read_col(0, w);
        check("no_edge_after_reset", {16'h0, w}, {16'h0, 16'h0000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
